// File: rtl/lsb_commit_queue.sv
// Load/store queue: in-order memory issue from the head, load result broadcast,
// stores released by ROB commit and kept across a misprediction flush.
module lsb_commit_queue #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned ROB_W     = 4,
  parameter int unsigned OP_W      = 6,
  parameter logic [31:0] MMIO_BASE = 32'h0003_0000,
  parameter int unsigned MMIO_SIZE = 8
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   lsb_clear,
  input  logic                   inst_valid,
  input  logic [OP_W-1:0]        inst_op,
  input  logic [ROB_W-1:0]       inst_robid,
  input  logic [31:0]            inst_val1,
  input  logic [31:0]            inst_val2,
  input  logic                   inst_has_rely1,
  input  logic                   inst_has_rely2,
  input  logic [ROB_W-1:0]       inst_rely1,
  input  logic [ROB_W-1:0]       inst_rely2,
  input  logic [31:0]            inst_imm,
  output logic                   lsb_full,
  output logic [$clog2(DEPTH):0] lsb_count,
  input  logic                   alu_valid,
  input  logic [ROB_W-1:0]       alu_robid,
  input  logic [31:0]            alu_val,
  input  logic                   rob_valid,
  input  logic [ROB_W-1:0]       rob_head_id,
  input  logic                   rob_commit_valid,
  input  logic [ROB_W-1:0]       rob_commit_id,
  output logic                   request,
  output logic                   load_or_store,
  output logic [OP_W-1:0]        mem_op,
  output logic [31:0]            mem_addr,
  output logic [31:0]            mem_data,
  input  logic                   mem_valid,
  input  logic [31:0]            mem_val,
  output logic                   lsb_valid,
  output logic [ROB_W-1:0]       lsb_robid,
  output logic [31:0]            lsb_val
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [OP_W-1:0] OP_SB = OP_W'(16);
  localparam logic [OP_W-1:0] OP_SH = OP_W'(17);
  localparam logic [OP_W-1:0] OP_SW = OP_W'(18);

  typedef enum logic [1:0] {IDLE, LOAD, STORE, DRAIN} state_t;

  state_t state, state_n;

  logic [PW-1:0] head, tail, head_n;
  logic [CW-1:0] count, ccount, ccount_n, resid;

  logic [DEPTH-1:0] busy, is_st, comm, qj_has, qk_has, keep;
  logic [ROB_W-1:0] tag_q [DEPTH];
  logic [ROB_W-1:0] qj    [DEPTH];
  logic [ROB_W-1:0] qk    [DEPTH];
  logic [31:0]      vj    [DEPTH];
  logic [31:0]      vk    [DEPTH];
  logic [31:0]      imm_q [DEPTH];
  logic [OP_W-1:0]  op_q  [DEPTH];
  logic [ROB_W-1:0] cur_tag;

  logic        h_store, h_mmio, h_rdy, can_issue, issue;
  logic        accept, flush, mem_done, ld_done, st_done;
  logic        commit_hit, st_fly;
  logic [31:0] h_addr;
  logic        d_qj_has, d_qk_has;
  logic [31:0] d_vj, d_vk;

  assign lsb_full  = (count == CW'(DEPTH));
  assign lsb_count = count;

  always_comb begin
    h_store = is_st[head];
    h_addr  = vj[head] + imm_q[head];
    h_mmio  = (h_addr - MMIO_BASE) < 32'(MMIO_SIZE);
    h_rdy   = busy[head] && !qj_has[head]
              && (!is_st[head] || !qk_has[head]);
    can_issue = 1'b0;
    if (state == IDLE && h_rdy) begin
      if (h_store)
        can_issue = comm[head];
      else
        can_issue = !h_mmio
                    || (rob_valid && rob_head_id == tag_q[head]);
    end
    issue    = rdy_in && can_issue;
    accept   = rdy_in && inst_valid && !lsb_full && !lsb_clear;
    flush    = rdy_in && lsb_clear;
    mem_done = rdy_in && mem_valid && state != IDLE;
    ld_done  = mem_done && state == LOAD;
    st_done  = mem_done && state == STORE;
    head_n   = head + PW'(issue);

    commit_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (rob_commit_valid && busy[i] && is_st[i] && !comm[i]
          && tag_q[i] == rob_commit_id)
        commit_hit = 1'b1;
    commit_hit = commit_hit && rdy_in;
    ccount_n = ccount + CW'(commit_hit) - CW'(st_done);

    // a store already handed to memory no longer occupies a slot
    st_fly = (state == STORE && !mem_valid) || (can_issue && h_store);
    resid  = ccount_n - CW'(st_fly);
    for (int i = 0; i < DEPTH; i++)
      keep[i] = CW'(PW'(i) - head_n) < resid;

    d_vj     = inst_val1;
    d_qj_has = inst_has_rely1;
    if (inst_has_rely1) begin
      if (alu_valid && alu_robid == inst_rely1) begin
        d_vj = alu_val;
        d_qj_has = 1'b0;
      end else if (lsb_valid && lsb_robid == inst_rely1) begin
        d_vj = lsb_val;
        d_qj_has = 1'b0;
      end
    end
    d_vk     = inst_val2;
    d_qk_has = inst_has_rely2;
    if (inst_has_rely2) begin
      if (alu_valid && alu_robid == inst_rely2) begin
        d_vk = alu_val;
        d_qk_has = 1'b0;
      end else if (lsb_valid && lsb_robid == inst_rely2) begin
        d_vk = lsb_val;
        d_qk_has = 1'b0;
      end
    end
  end

  always_comb begin
    state_n = state;
    if (rdy_in) begin
      unique case (state)
        IDLE:
          if (can_issue)
            state_n = h_store ? STORE : (lsb_clear ? DRAIN : LOAD);
        LOAD:
          if (mem_valid) state_n = IDLE;
          else if (lsb_clear) state_n = DRAIN;
        STORE, DRAIN:
          if (mem_valid) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      ccount <= '0;
      busy <= '0;
      is_st <= '0;
      comm <= '0;
      qj_has <= '0;
      qk_has <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i] <= '0;
        qj[i] <= '0;
        qk[i] <= '0;
        vj[i] <= '0;
        vk[i] <= '0;
        imm_q[i] <= '0;
        op_q[i] <= '0;
      end
      cur_tag <= '0;
      request <= 1'b0;
      load_or_store <= 1'b0;
      mem_op <= '0;
      mem_addr <= '0;
      mem_data <= '0;
      lsb_valid <= 1'b0;
      lsb_robid <= '0;
      lsb_val <= '0;
    end else if (rdy_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy[i] && qj_has[i]) begin
          if (alu_valid && alu_robid == qj[i]) begin
            vj[i] <= alu_val;
            qj_has[i] <= 1'b0;
          end else if (lsb_valid && lsb_robid == qj[i]) begin
            vj[i] <= lsb_val;
            qj_has[i] <= 1'b0;
          end
        end
        if (busy[i] && qk_has[i]) begin
          if (alu_valid && alu_robid == qk[i]) begin
            vk[i] <= alu_val;
            qk_has[i] <= 1'b0;
          end else if (lsb_valid && lsb_robid == qk[i]) begin
            vk[i] <= lsb_val;
            qk_has[i] <= 1'b0;
          end
        end
        if (rob_commit_valid && busy[i] && is_st[i]
            && tag_q[i] == rob_commit_id)
          comm[i] <= 1'b1;
      end

      if (accept) begin
        busy[tail] <= 1'b1;
        comm[tail] <= 1'b0;
        is_st[tail] <= inst_op == OP_SB || inst_op == OP_SH
                       || inst_op == OP_SW;
        op_q[tail] <= inst_op;
        tag_q[tail] <= inst_robid;
        imm_q[tail] <= inst_imm;
        vj[tail] <= d_vj;
        qj_has[tail] <= d_qj_has;
        qj[tail] <= inst_rely1;
        vk[tail] <= d_vk;
        qk_has[tail] <= d_qk_has;
        qk[tail] <= inst_rely2;
        tail <= tail + PW'(1);
      end

      if (issue) begin
        busy[head] <= 1'b0;
        comm[head] <= 1'b0;
        head <= head_n;
        request <= 1'b1;
        load_or_store <= h_store;
        mem_op <= op_q[head];
        mem_addr <= h_addr;
        mem_data <= vk[head];
        cur_tag <= tag_q[head];
      end else if (mem_done) begin
        request <= 1'b0;
      end

      lsb_valid <= ld_done && !lsb_clear;
      if (ld_done) begin
        lsb_robid <= cur_tag;
        lsb_val <= mem_val;
      end

      count <= count + CW'(accept) - CW'(issue);
      ccount <= ccount_n;

      if (flush) begin
        count <= resid;
        tail <= head_n + resid[PW-1:0];
        for (int i = 0; i < DEPTH; i++)
          if (!keep[i]) begin
            busy[i] <= 1'b0;
            comm[i] <= 1'b0;
          end
      end
    end
  end

endmodule

// File: tb/tb_lsb_commit_queue.sv
// Directed bench for lsb_commit_queue: dispatch, wakeup, commit,
// flush, MMIO ordering and async reset.
module tb_lsb_commit_queue;

  localparam logic [5:0] LW = 6'd13;
  localparam logic [5:0] SW = 6'd18;

  logic        clk_in, rst_in, rdy_in, lsb_clear;
  logic        inst_valid;
  logic [5:0]  inst_op;
  logic [3:0]  inst_robid, inst_rely1, inst_rely2;
  logic [31:0] inst_val1, inst_val2, inst_imm;
  logic        inst_has_rely1, inst_has_rely2;
  logic        lsb_full;
  logic [3:0]  lsb_count;
  logic        alu_valid;
  logic [3:0]  alu_robid;
  logic [31:0] alu_val;
  logic        rob_valid, rob_commit_valid;
  logic [3:0]  rob_head_id, rob_commit_id;
  logic        request, load_or_store;
  logic [5:0]  mem_op;
  logic [31:0] mem_addr, mem_data;
  logic        mem_valid;
  logic [31:0] mem_val;
  logic        lsb_valid;
  logic [3:0]  lsb_robid;
  logic [31:0] lsb_val;

  int n_chk = 0;
  int n_err = 0;

  lsb_commit_queue dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .lsb_clear(lsb_clear),
    .inst_valid(inst_valid), .inst_op(inst_op),
    .inst_robid(inst_robid),
    .inst_val1(inst_val1), .inst_val2(inst_val2),
    .inst_has_rely1(inst_has_rely1),
    .inst_has_rely2(inst_has_rely2),
    .inst_rely1(inst_rely1), .inst_rely2(inst_rely2),
    .inst_imm(inst_imm),
    .lsb_full(lsb_full), .lsb_count(lsb_count),
    .alu_valid(alu_valid), .alu_robid(alu_robid),
    .alu_val(alu_val),
    .rob_valid(rob_valid), .rob_head_id(rob_head_id),
    .rob_commit_valid(rob_commit_valid),
    .rob_commit_id(rob_commit_id),
    .request(request), .load_or_store(load_or_store),
    .mem_op(mem_op), .mem_addr(mem_addr),
    .mem_data(mem_data),
    .mem_valid(mem_valid), .mem_val(mem_val),
    .lsb_valid(lsb_valid), .lsb_robid(lsb_robid),
    .lsb_val(lsb_val)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic disp(input logic [5:0] op, input logic [3:0] tag,
                      input logic [31:0] v1, input logic [31:0] v2,
                      input logic [31:0] imm,
                      input logic h1, input logic [3:0] r1,
                      input logic h2, input logic [3:0] r2);
    inst_valid = 1'b1;
    inst_op = op;
    inst_robid = tag;
    inst_val1 = v1;
    inst_val2 = v2;
    inst_imm = imm;
    inst_has_rely1 = h1;
    inst_rely1 = r1;
    inst_has_rely2 = h2;
    inst_rely2 = r2;
    step();
    inst_valid = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!request && n < 20) begin
      step();
      n++;
    end
    chk(tag, 32'(request), 32'd1);
  endtask

  task automatic ack(input logic [31:0] v);
    mem_valid = 1'b1;
    mem_val = v;
    step();
    mem_valid = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1;
    rdy_in = 1'b1;
    lsb_clear = 1'b0;
    inst_valid = 1'b0;
    inst_op = '0;
    inst_robid = '0;
    inst_val1 = '0;
    inst_val2 = '0;
    inst_imm = '0;
    inst_has_rely1 = 1'b0;
    inst_has_rely2 = 1'b0;
    inst_rely1 = '0;
    inst_rely2 = '0;
    alu_valid = 1'b0;
    alu_robid = '0;
    alu_val = '0;
    rob_valid = 1'b0;
    rob_head_id = '0;
    rob_commit_valid = 1'b0;
    rob_commit_id = '0;
    mem_valid = 1'b0;
    mem_val = '0;

    #12;
    chk("rst_count", 32'(lsb_count), 32'd0);
    chk("rst_full", 32'(lsb_full), 32'd0);
    chk("rst_req", 32'(request), 32'd0);
    chk("rst_lsbv", 32'(lsb_valid), 32'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
    step();

    // load rs1=0x1000 imm=-4
    disp(LW, 4'd1, 32'h1000, 32'h0, 32'hFFFF_FFFC,
         1'b0, 4'd0, 1'b0, 4'd0);
    wait_req("ld_req");
    chk("ld_addr", mem_addr, 32'h0000_0FFC);
    chk("ld_kind", 32'(load_or_store), 32'd0);
    chk("ld_count", 32'(lsb_count), 32'd0);
    ack(32'h0000_DEAD);
    chk("ld_reqoff", 32'(request), 32'd0);
    chk("ld_bv", 32'(lsb_valid), 32'd1);
    chk("ld_btag", 32'(lsb_robid), 32'd1);
    chk("ld_bval", lsb_val, 32'h0000_DEAD);
    step();
    chk("ld_pulse", 32'(lsb_valid), 32'd0);

    // fill all eight slots with loads waiting on tag 9
    for (int k = 0; k < 8; k++)
      disp(LW, 4'(k), 32'h0, 32'h0, 32'(4 * k),
           1'b1, 4'd9, 1'b0, 4'd0);
    chk("fill_count", 32'(lsb_count), 32'd8);
    chk("fill_full", 32'(lsb_full), 32'd1);
    disp(LW, 4'd8, 32'h0, 32'h0, 32'h40, 1'b1, 4'd9, 1'b0, 4'd0);
    chk("ninth_ign", 32'(lsb_count), 32'd8);
    alu_valid = 1'b1;
    alu_robid = 4'd9;
    alu_val = 32'h2000;
    step();
    alu_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      wait_req("drain_req");
      chk("drain_addr", mem_addr, 32'h2000 + 32'(4 * k));
      ack(32'h100 + 32'(k));
      chk("drain_bv", 32'(lsb_valid), 32'd1);
      chk("drain_btag", 32'(lsb_robid), 32'(k));
      chk("drain_bval", lsb_val, 32'h100 + 32'(k));
    end
    repeat (3) step();
    chk("drain_count", 32'(lsb_count), 32'd0);
    chk("drain_idle", 32'(request), 32'd0);

    // store data woken by ALU in its dispatch cycle
    alu_valid = 1'b1;
    alu_robid = 4'd3;
    alu_val = 32'h55;
    disp(SW, 4'd4, 32'h2000, 32'h0, 32'h8, 1'b0, 4'd0, 1'b1, 4'd3);
    alu_valid = 1'b0;
    repeat (4) step();
    chk("st_hold", 32'(request), 32'd0);
    rob_commit_valid = 1'b1;
    rob_commit_id = 4'd4;
    step();
    rob_commit_valid = 1'b0;
    wait_req("st_req");
    chk("st_kind", 32'(load_or_store), 32'd1);
    chk("st_data", mem_data, 32'h55);
    chk("st_addr", mem_addr, 32'h2008);
    ack(32'h0);
    chk("st_reqoff", 32'(request), 32'd0);
    chk("st_nobc", 32'(lsb_valid), 32'd0);

    // flush keeps committed stores, drains the in-flight load
    disp(LW, 4'd5, 32'h3000, 32'h0, 32'h0, 1'b0, 4'd0, 1'b0, 4'd0);
    disp(SW, 4'd6, 32'h4000, 32'h11, 32'h0, 1'b0, 4'd0, 1'b0, 4'd0);
    disp(SW, 4'd7, 32'h4000, 32'h22, 32'h4, 1'b0, 4'd0, 1'b0, 4'd0);
    disp(LW, 4'd8, 32'h4000, 32'h0, 32'h8, 1'b0, 4'd0, 1'b0, 4'd0);
    disp(SW, 4'd10, 32'h4000, 32'h33, 32'hC, 1'b0, 4'd0, 1'b0, 4'd0);
    chk("fl_pre", 32'(lsb_count), 32'd4);
    rob_commit_valid = 1'b1;
    rob_commit_id = 4'd6;
    step();
    rob_commit_id = 4'd7;
    step();
    rob_commit_valid = 1'b0;
    lsb_clear = 1'b1;
    step();
    lsb_clear = 1'b0;
    chk("fl_count", 32'(lsb_count), 32'd2);
    chk("fl_ldreq", 32'(request), 32'd1);
    ack(32'h0BAD);
    chk("fl_drain", 32'(lsb_valid), 32'd0);
    wait_req("fl_s1req");
    chk("fl_s1kind", 32'(load_or_store), 32'd1);
    chk("fl_s1addr", mem_addr, 32'h4000);
    chk("fl_s1data", mem_data, 32'h11);
    ack(32'h0);
    chk("fl_s1bc", 32'(lsb_valid), 32'd0);
    wait_req("fl_s2req");
    chk("fl_s2addr", mem_addr, 32'h4004);
    chk("fl_s2data", mem_data, 32'h22);
    ack(32'h0);
    repeat (4) step();
    chk("fl_gone", 32'(request), 32'd0);
    chk("fl_empty", 32'(lsb_count), 32'd0);

    // MMIO load waits for ROB head
    rob_valid = 1'b1;
    rob_head_id = 4'd2;
    disp(LW, 4'd11, 32'h0003_0000, 32'h0, 32'h0,
         1'b0, 4'd0, 1'b0, 4'd0);
    repeat (3) step();
    chk("mmio_hold", 32'(request), 32'd0);
    rob_head_id = 4'd11;
    wait_req("mmio_req");
    chk("mmio_addr", mem_addr, 32'h0003_0000);
    ack(32'h77);
    chk("mmio_bv", 32'(lsb_valid), 32'd1);
    chk("mmio_bval", lsb_val, 32'h77);
    rob_head_id = 4'd2;
    disp(LW, 4'd12, 32'h0003_0004, 32'h0, 32'h4,
         1'b0, 4'd0, 1'b0, 4'd0);
    step();
    chk("mmio_edge", 32'(request), 32'd1);
    chk("edge_addr", mem_addr, 32'h0003_0008);
    rdy_in = 1'b0;
    mem_valid = 1'b1;
    mem_val = 32'h99;
    step();
    chk("rdy_hold", 32'(request), 32'd1);
    rdy_in = 1'b1;
    step();
    mem_valid = 1'b0;
    chk("rdy_bv", 32'(lsb_valid), 32'd1);
    chk("rdy_bval", lsb_val, 32'h99);

    // async reset while a load is in flight
    rob_valid = 1'b0;
    disp(LW, 4'd13, 32'h5000, 32'h0, 32'h0, 1'b0, 4'd0, 1'b0, 4'd0);
    wait_req("ar_req");
    disp(LW, 4'd14, 32'h5000, 32'h0, 32'h0, 1'b1, 4'd15, 1'b0, 4'd0);
    chk("ar_pre", 32'(lsb_count), 32'd1);
    #3;
    rst_in = 1'b1;
    #1;
    chk("ar_req0", 32'(request), 32'd0);
    chk("ar_cnt0", 32'(lsb_count), 32'd0);
    chk("ar_bv0", 32'(lsb_valid), 32'd0);
    step();
    rst_in = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
